// File: rtl/shifter_pkg.sv
// Shared op encoding and per-stage control payload for the pipelined barrel shifter.
// Rotate support is selected at build time with SHIFTER_ROTATE_EN.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  // Width-independent part of a stage entry; data and shamt sizes depend on BITS
  // and are attached in the top-level stage struct.
  typedef struct packed {
    logic      valid;
    shift_op_e op;
    logic      pad;
    logic      sign;
  } stage_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One fixed-distance conditional shift used by a single pipeline level.
// With SHIFTER_ROTATE_EN undefined, op ROR decodes as SRL and no wrap path exists.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int BITS = 32,
  parameter int DIST = 1
) (
  input  logic            en_i,
  input  shift_op_e       op_i,
  input  logic            pad_i,
  input  logic            sign_i,
  input  logic [BITS-1:0] data_i,
  output logic [BITS-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      unique case (op_i)
        SHIFT_SLL: data_o = {data_i[BITS-DIST-1:0], {DIST{pad_i}}};
        SHIFT_SRA: data_o = {{DIST{sign_i}}, data_i[BITS-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
        SHIFT_ROR: data_o = {data_i[DIST-1:0], data_i[BITS-1:DIST]};
        SHIFT_SRL: data_o = {{DIST{pad_i}}, data_i[BITS-1:DIST]};
`else
        SHIFT_SRL,
        SHIFT_ROR: data_o = {{DIST{pad_i}}, data_i[BITS-1:DIST]};
`endif
        default:   data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: one power-of-two distance per stage, global stall.
// Define SHIFTER_ROTATE_EN to make op 2'b11 rotate right instead of SRL.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int BITS    = 32,
  localparam int SHAMT_W = $clog2(BITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITS-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic               in_pad,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    out_data
);

  typedef struct packed {
    stage_ctrl_t        ctrl;
    logic [SHAMT_W-1:0] shamt;
    logic [BITS-1:0]    data;
  } stage_t;

  stage_t inStage;
  stage_t stage_q [SHAMT_W];
  stage_t stage_d [SHAMT_W];
  logic   stall;

  assign out_valid = stage_q[SHAMT_W-1].ctrl.valid;
  assign out_data  = stage_q[SHAMT_W-1].data;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // The sign bit is sampled once here so SRA fills stay correct after earlier
  // stages have already moved other bits into the MSB.
  always_comb begin
    inStage.ctrl.valid = in_valid;
    inStage.ctrl.op    = shift_op_e'(in_op);
    inStage.ctrl.pad   = in_pad;
    inStage.ctrl.sign  = in_data[BITS-1];
    inStage.shamt      = in_shamt;
    inStage.data       = in_data;
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    stage_t          src;
    logic [BITS-1:0] shifted;

    if (k == 0) begin : g_first
      assign src = inStage;
    end else begin : g_rest
      assign src = stage_q[k-1];
    end

    shift_stage #(
      .BITS (BITS),
      .DIST (1 << k)
    ) u_shift (
      .en_i   (src.shamt[k]),
      .op_i   (src.ctrl.op),
      .pad_i  (src.ctrl.pad),
      .sign_i (src.ctrl.sign),
      .data_i (src.data),
      .data_o (shifted)
    );

    assign stage_d[k] = {src.ctrl, src.shamt, shifted};
  end

  // Flush beats stall and drops the entry being offered; a stall freezes every
  // stage, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        stage_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        stage_q[k].ctrl.valid <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter at BITS = 8 (latency 3).
// Expected results come from an arithmetic shift model and an in-order scoreboard.
module tb_pipelined_barrel_shifter;

  localparam int BITS = 8;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       flush     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] in_data   = '0;
  logic [2:0] in_shamt  = '0;
  logic [1:0] in_op     = '0;
  logic       in_pad    = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int total    = 0;
  int bad      = 0;
  int popCount = 0;
  logic [7:0] expQ[$];

  typedef struct {
    logic [7:0] data;
    logic [2:0] shamt;
    logic [1:0] op;
    logic       pad;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  pipelined_barrel_shifter #(
    .BITS (BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_pad    (in_pad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  // Shift semantics written as plain integer arithmetic on an 8-bit value.
  function automatic logic [7:0] refShift(logic [7:0] d, int s, logic [1:0] op, logic pad);
    int x;
    int hi;
    int lo;
    int r;
    x  = int'(d);
    hi = 255 ^ (255 >> s);
    lo = (1 << s) - 1;
    case (op)
      2'b00:   r = (x << s) | (pad ? lo : 0);
      2'b01:   r = (x >> s) | (pad ? hi : 0);
      2'b10:   r = (x >> s) | (d[7] ? hi : 0);
`ifdef SHIFTER_ROTATE_EN
      default: r = (x >> s) | (x << (8 - s));
`else
      default: r = (x >> s) | (pad ? hi : 0);
`endif
    endcase
    return r[7:0];
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op,
                        input logic pad, input logic [7:0] exp);
    vec_t v;
    v.data = d; v.shamt = s; v.op = op; v.pad = pad; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One cycle of handshake traffic, entered and left just after a falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] s,
                               input logic [1:0] op, input logic pad, input logic ordy,
                               input logic fl, output logic acc, output logic rdy);
    logic       pop;
    logic [7:0] od;
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    in_pad    = pad;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = in_ready;
    acc = v && in_ready && !fl;
    pop = out_valid && ordy;
    od  = out_data;
    @(posedge clk);
    if (pop) begin
      popCount++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out: got 0x%0h expected no output at %0t", od, $time);
      end else begin
        checkOutput("stream_data", int'(od), int'(expQ.pop_front()));
      end
    end
    if (fl) expQ.delete();
    else if (acc) expQ.push_back(refShift(d, int'(s), op, pad));
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Single isolated transfer into an empty pipe; checks latency and result.
  task automatic runVector(input vec_t v, input string name);
    int lat;
    in_valid  = 1'b1;
    in_data   = v.data;
    in_shamt  = v.shamt;
    in_op     = v.op;
    in_pad    = v.pad;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, lat, 3);
    checkOutput({name, "_data"}, int'(out_data), int'(v.exp));
    @(negedge clk);
  endtask

  initial begin
    logic       acc;
    logic       rdy;
    logic [7:0] streamData[4];
    int         sent;
    int         stallLeft;
    int         popStart;
    bit         seenValid;
    int         n;
    vec_t       fv;

    addVec(8'h0F, 3'd4, 2'b00, 1'b0, 8'hF0);
    addVec(8'h0F, 3'd4, 2'b00, 1'b1, 8'hFF);
    addVec(8'h80, 3'd3, 2'b01, 1'b0, 8'h10);
    addVec(8'h80, 3'd3, 2'b10, 1'b0, 8'hF0);
    addVec(8'h40, 3'd2, 2'b10, 1'b0, 8'h10);
`ifdef SHIFTER_ROTATE_EN
    addVec(8'h0F, 3'd4, 2'b11, 1'b0, 8'hF0);
    addVec(8'h96, 3'd3, 2'b11, 1'b1, 8'hD2);
`else
    addVec(8'h0F, 3'd4, 2'b11, 1'b0, 8'h00);
    addVec(8'h96, 3'd3, 2'b11, 1'b1, 8'hF2);
`endif
    addVec(8'h0F, 3'd0, 2'b11, 1'b0, 8'h0F);
    addVec(8'hA5, 3'd0, 2'b00, 1'b1, 8'hA5);
    addVec(8'hA5, 3'd0, 2'b10, 1'b1, 8'hA5);
    addVec(8'h81, 3'd1, 2'b01, 1'b1, 8'hC0);
    addVec(8'h81, 3'd1, 2'b00, 1'b1, 8'h03);
    addVec(8'hC3, 3'd7, 2'b10, 1'b0, 8'hFF);
    addVec(8'h43, 3'd7, 2'b10, 1'b1, 8'h00);

    $display("[TB] reset state");
    #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed vectors");
    foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] backpressure stream");
    streamData = '{8'h01, 8'h02, 8'h03, 8'h04};
    sent = 0; stallLeft = 0; seenValid = 1'b0; popStart = popCount;
    for (int cyc = 0; cyc < 20 && (sent < 4 || expQ.size() > 0); cyc++) begin
      if (!seenValid && out_valid) begin
        seenValid = 1'b1;
        stallLeft = 2;
      end
      applyStimulus(sent < 4, streamData[sent < 4 ? sent : 0], 3'd1, 2'b00, 1'b0,
                    stallLeft == 0, 1'b0, acc, rdy);
      if (stallLeft > 0) begin
        checkOutput("stall_in_ready", int'(rdy), 0);
        stallLeft--;
      end else begin
        checkOutput("run_in_ready", int'(rdy), 1);
      end
      if (acc) sent++;
    end
    checkOutput("stream_out_count", popCount - popStart, 4);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 8'h11, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
    applyStimulus(1'b1, 8'h22, 3'd2, 2'b01, 1'b0, 1'b1, 1'b0, acc, rdy);
    applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, acc, rdy);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_out_data", int'(out_data), 0);
    checkOutput("midreset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    for (int i = 0; i < 5; i++) begin
      checkOutput("post_reset_out_valid", int'(out_valid), 0);
      applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
    end

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h31, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
    applyStimulus(1'b1, 8'h32, 3'd2, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
    applyStimulus(1'b1, 8'h33, 3'd3, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
    applyStimulus(1'b1, 8'h34, 3'd1, 2'b00, 1'b0, 1'b0, 1'b1, acc, rdy);
    for (int i = 0; i < 4; i++) begin
      checkOutput("post_flush_out_valid", int'(out_valid), 0);
      applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
    end
    fv.data = 8'h3C; fv.shamt = 3'd2; fv.op = 2'b01; fv.pad = 1'b1; fv.exp = 8'hCF;
    runVector(fv, "after_flush");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 2'($urandom),
                    1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                    acc, rdy);
    end
    n = 0;
    while (expQ.size() > 0 && n < 40) begin
      applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, acc, rdy);
      n++;
    end
    checkOutput("drain_pending", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
